// File: rtl/sbox_pkg.sv
// Shared S-box tables and lookup helper for the byte-substitution datapath.
// The inverse table is derived from the forward one so the two can never drift apart.
package sbox_pkg;

  localparam int NLANES_MAX = 16;

  // Index 0 is the leftmost byte of the concatenation below.
  typedef logic [0:255][7:0] sbox_t;

  localparam sbox_t SBOX_FWD = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic sbox_t invert_sbox(input sbox_t fwd);
    sbox_t inv;
    inv = '0;
    for (int i = 0; i < 256; i++) begin
      inv[fwd[i]] = 8'(i);
    end
    return inv;
  endfunction

  localparam sbox_t SBOX_INV = invert_sbox(SBOX_FWD);

  function automatic logic [7:0] sbox_lookup(input logic [7:0] b, input logic inv);
    return inv ? SBOX_INV[b] : SBOX_FWD[b];
  endfunction

endpackage

// File: rtl/sbox_lane.sv
// One byte lane of the substitution stage: forward or inverse S-box, or pass-through.
module sbox_lane
  import sbox_pkg::*;
(
  input  logic       inv_i,
  input  logic       en_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  always_comb begin
    data_o = data_i;
    if (en_i) begin
      data_o = sbox_lookup(data_i, inv_i);
    end
  end

endmodule

// File: rtl/sbox_pipe.sv
// Two-stage valid/ready pipeline around NLANES independent S-box lanes.
// S1 captures the raw word, S2 captures the substituted word and drives the outputs directly.
module sbox_pipe #(
  parameter int NLANES = 4,
  localparam int DATAW = 8 * NLANES
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATAW-1:0]  in_data_i,
  input  logic              in_inv_i,
  input  logic [NLANES-1:0] in_mask_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATAW-1:0]  out_data_o
);

  logic              s1_valid_q;
  logic [DATAW-1:0]  s1_data_q;
  logic              s1_inv_q;
  logic [NLANES-1:0] s1_mask_q;
  logic              s2_valid_q;
  logic [DATAW-1:0]  s2_data_q;
  logic [DATAW-1:0]  s2_data_d;
  logic              s1_adv;
  logic              s2_adv;

  // A stage may advance when it is empty or the stage after it is moving.
  always_comb begin
    s2_adv = !s2_valid_q || out_ready_i;
    s1_adv = !s1_valid_q || s2_adv;
  end

  for (genvar k = 0; k < NLANES; k++) begin : g_lane
    sbox_lane u_lane (
      .inv_i  (s1_inv_q),
      .en_i   (s1_mask_q[k]),
      .data_i (s1_data_q[8*k +: 8]),
      .data_o (s2_data_d[8*k +: 8])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_inv_q   <= 1'b0;
      s1_mask_q  <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid_i;
      s1_data_q  <= in_data_i;
      s1_inv_q   <= in_inv_i;
      s1_mask_q  <= in_mask_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      s2_data_q  <= s2_data_d;
    end
  end

  assign in_ready_o  = s1_adv;
  assign out_valid_o = s2_valid_q;
  assign out_data_o  = s2_data_q;

endmodule

// File: tb/tb_sbox_pipe.sv
// Directed bench for sbox_pipe: latency, modes, masking, back-pressure and mid-stream reset.
module tb_sbox_pipe;

  logic        clk_i;
  logic        rst_ni;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_data_i;
  logic        in_inv_i;
  logic [3:0]  in_mask_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_data_o;

  int assertCount = 0;
  int failCount   = 0;

  logic [31:0] txData  [64];
  logic        txInv   [64];
  logic [3:0]  txMask  [64];
  logic [31:0] expData [64];
  logic [31:0] rxData  [64];
  logic [31:0] sweepIn [64];
  bit          checkData;
  int          streamCycles;

  sbox_pipe #(.NLANES(4)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .in_inv_i    (in_inv_i),
    .in_mask_i   (in_mask_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] data, input logic inv, input logic [3:0] mask);
    in_valid_i = valid;
    in_data_i  = data;
    in_inv_i   = inv;
    in_mask_i  = mask;
  endtask

  // Cycle loop entered at posedge+1; inputs change there, everything is sampled at the negedge.
  task automatic runStream(input int n, input bit randReady, output int cycles);
    int tx = 0;
    int rx = 0;
    int occ = 0;
    int cyc = 0;
    bit holding = 0;
    bit inT;
    bit outT;
    logic [31:0] heldData = '0;
    while (rx < n && cyc < 2000) begin
      if (tx < n) applyStimulus(1'b1, txData[tx], txInv[tx], txMask[tx]);
      else        applyStimulus(1'b0, 32'h0, 1'b0, 4'h0);
      if (!randReady)               out_ready_i = 1'b1;
      else if (cyc >= 2 && cyc < 5) out_ready_i = 1'b0;
      else                          out_ready_i = 1'($urandom_range(0, 1));
      @(negedge clk_i);
      checkOutput("in_ready", {31'b0, in_ready_o}, {31'b0, (occ < 2) || out_ready_i});
      if (holding) begin
        checkOutput("hold_valid", {31'b0, out_valid_o}, 32'h1);
        checkOutput("hold_data", out_data_o, heldData);
      end
      if (out_valid_o && checkData && rx < n) checkOutput("out_data", out_data_o, expData[rx]);
      inT  = in_valid_i && in_ready_o;
      outT = out_valid_o && out_ready_i;
      holding  = out_valid_o && !out_ready_i;
      heldData = out_data_o;
      if (outT) begin
        if (rx < n) rxData[rx] = out_data_o;
        rx++;
        occ--;
      end
      if (inT) begin
        tx++;
        occ++;
      end
      @(posedge clk_i);
      #1;
      cyc++;
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 4'h0);
    checkOutput("stream_count", 32'(rx), 32'(n));
    cycles = cyc;
  endtask

  initial begin
    checkData = 1'b1;
    rst_ni = 1'b0;
    out_ready_i = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 4'h0);
    #1;
    checkOutput("rst_out_valid", {31'b0, out_valid_o}, 32'h0);
    checkOutput("rst_out_data", out_data_o, 32'h0);
    checkOutput("rst_in_ready", {31'b0, in_ready_o}, 32'h1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Single word latency: accepted at edge N, visible after N+1, gone after N+2.
    applyStimulus(1'b1, 32'h00_01_52_FF, 1'b0, 4'hF);
    out_ready_i = 1'b1;
    checkOutput("lat_in_ready", {31'b0, in_ready_o}, 32'h1);
    @(posedge clk_i);
    #1;
    applyStimulus(1'b0, 32'h0, 1'b0, 4'h0);
    checkOutput("lat_not_yet", {31'b0, out_valid_o}, 32'h0);
    checkOutput("lat_in_ready2", {31'b0, in_ready_o}, 32'h1);
    @(posedge clk_i);
    #1;
    checkOutput("lat_valid", {31'b0, out_valid_o}, 32'h1);
    checkOutput("lat_data", out_data_o, 32'h63_7C_00_16);
    @(posedge clk_i);
    #1;
    checkOutput("lat_drained", {31'b0, out_valid_o}, 32'h0);

    txData[0] = 32'h63_7C_00_16; txInv[0] = 1'b1; txMask[0] = 4'hF; expData[0] = 32'h00_01_52_FF;
    runStream(1, 1'b0, streamCycles);
    txData[0] = 32'h00_00_00_00; txInv[0] = 1'b0; txMask[0] = 4'h5; expData[0] = 32'h00_63_00_63;
    runStream(1, 1'b0, streamCycles);

    // Back-pressure: lanes 3..1 substituted with known values, lane 0 carries the sequence number.
    for (int i = 0; i < 10; i++) begin
      txData[i]  = {8'h00, 8'h01, 8'h52, 8'(i)};
      txInv[i]   = 1'b0;
      txMask[i]  = 4'hE;
      expData[i] = {8'h63, 8'h7C, 8'h00, 8'(i)};
    end
    runStream(10, 1'b1, streamCycles);

    // Alternating mode on back-to-back words at full rate.
    for (int i = 0; i < 8; i++) begin
      txInv[i]   = 1'(i % 2);
      txMask[i]  = 4'hF;
      txData[i]  = (i % 2 == 0) ? 32'h00_01_52_FF : 32'h63_7C_00_16;
      expData[i] = (i % 2 == 0) ? 32'h63_7C_00_16 : 32'h00_01_52_FF;
    end
    runStream(8, 1'b0, streamCycles);
    checkOutput("mode_throughput", 32'(streamCycles), 32'd10);

    // Full sweep forward, spot-checked, then back through the inverse.
    checkData = 1'b0;
    for (int j = 0; j < 64; j++) begin
      sweepIn[j] = {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)};
      txData[j]  = sweepIn[j];
      txInv[j]   = 1'b0;
      txMask[j]  = 4'hF;
    end
    runStream(64, 1'b0, streamCycles);
    checkOutput("sweep_fwd_00", rxData[0], 32'h7B_77_7C_63);
    checkOutput("sweep_fwd_50", rxData[20], 32'hED_00_D1_53);
    checkOutput("sweep_fwd_80", rxData[32], 32'hEC_13_0C_CD);
    checkOutput("sweep_fwd_FC", rxData[63], 32'h16_BB_54_B0);
    checkData = 1'b1;
    for (int j = 0; j < 64; j++) begin
      txData[j]  = rxData[j];
      txInv[j]   = 1'b1;
      expData[j] = sweepIn[j];
    end
    runStream(64, 1'b1, streamCycles);

    // Reset with two words in flight.
    out_ready_i = 1'b0;
    applyStimulus(1'b1, 32'hAAAA_0001, 1'b0, 4'hF);
    @(posedge clk_i);
    #1;
    applyStimulus(1'b1, 32'hAAAA_0002, 1'b0, 4'hF);
    @(posedge clk_i);
    #1;
    applyStimulus(1'b0, 32'h0, 1'b0, 4'h0);
    checkOutput("pre_rst_valid", {31'b0, out_valid_o}, 32'h1);
    checkOutput("pre_rst_ready", {31'b0, in_ready_o}, 32'h0);
    #1;
    rst_ni = 1'b0;
    #1;
    checkOutput("mid_rst_valid", {31'b0, out_valid_o}, 32'h0);
    checkOutput("mid_rst_ready", {31'b0, in_ready_o}, 32'h1);
    checkOutput("mid_rst_data", out_data_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    txData[0] = 32'h52_52_01_00; txInv[0] = 1'b0; txMask[0] = 4'hF; expData[0] = 32'h00_00_7C_63;
    runStream(1, 1'b0, streamCycles);
    for (int i = 0; i < 3; i++) begin
      checkOutput("post_rst_idle", {31'b0, out_valid_o}, 32'h0);
      @(posedge clk_i);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
